// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory behind the MEM stage with wait states and lane handling.
// Optional macro DMEM_MISALIGN_CHECK_EN enables fault reporting on resp_err.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_amp,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned LAW   = ADDR_WIDTH + 2;
   localparam int unsigned CW    = 4;
   localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic              we_q, uns_q;
   logic [LAW-1:0]    addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        amp_q;
   logic [1:0]        size_q;
   logic              req_ready_q, resp_valid_q, resp_err_q;
   logic [31:0]       resp_rdata_q;
   logic [31:0]       mem_q [DEPTH];

   logic              accept_c, access_c, fault_c;
   logic              we_d, uns_d;
   logic [LAW-1:0]    addr_d;
   logic [31:0]       wdata_d, word_c, load_c, rdata_d;
   logic [3:0]        amp_d;
   logic [1:0]        size_d;
   logic [7:0]        byte_c;
   logic [15:0]       half_c;
   logic              unused_addr;

   assign unused_addr = ^req_addr[31:LAW];

   // With zero wait states the access happens on the accepting edge, so use the live request.
   always_comb begin
      accept_c = (state_q == S_IDLE) && req_valid;
      if (state_q == S_IDLE) begin
         we_d    = req_we;
         addr_d  = req_addr[LAW-1:0];
         wdata_d = req_wdata;
         amp_d   = req_amp;
         size_d  = req_size;
         uns_d   = req_unsigned;
      end else begin
         we_d    = we_q;
         addr_d  = addr_q;
         wdata_d = wdata_q;
         amp_d   = amp_q;
         size_d  = size_q;
         uns_d   = uns_q;
      end
      access_c = (accept_c && (WAIT_STATES == 0)) || ((state_q == S_WAIT) && (cnt_q == '0));
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   always_comb begin
      case (size_d)
         2'b00:   fault_c = 1'b1;
         2'b01:   fault_c = (addr_d[1:0] != 2'b00);
         2'b10:   fault_c = addr_d[0];
         default: fault_c = 1'b0;
      endcase
   end
`else
   assign fault_c = 1'b0;
`endif

   // Lane extraction and extension; reserved size falls through to word.
   always_comb begin
      word_c = mem_q[addr_d[LAW-1:2]];
      byte_c = word_c[{addr_d[1:0], 3'b000} +: 8];
      half_c = addr_d[1] ? word_c[31:16] : word_c[15:0];
      case (size_d)
         2'b11:   load_c = {{24{byte_c[7] & ~uns_d}}, byte_c};
         2'b10:   load_c = {{16{half_c[15] & ~uns_d}}, half_c};
         default: load_c = word_c;
      endcase
      rdata_d = (we_d || fault_c) ? 32'd0 : load_c;
   end

   always_ff @(posedge clk) begin
      if (!reset && access_c && we_d && !fault_c) begin
         for (int i = 0; i < 4; i++) begin
            if (amp_d[i]) mem_q[addr_d[LAW-1:2]][8*i +: 8] <= wdata_d[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_c) begin
                  we_q        <= req_we;
                  addr_q      <= req_addr[LAW-1:0];
                  wdata_q     <= req_wdata;
                  amp_q       <= req_amp;
                  size_q      <= req_size;
                  uns_q       <= req_unsigned;
                  req_ready_q <= 1'b0;
                  if (WAIT_STATES == 0) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= rdata_d;
                     resp_err_q   <= fault_c;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (access_c) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= rdata_d;
                  resp_err_q   <= fault_c;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  state_q      <= S_IDLE;
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
endmodule
